// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer
// Purpose  : Control sequencer for a time-multiplexed FIR. It clears the
//            sample history, writes each accepted sample, walks all taps
//            newest-to-oldest and issues latency-aligned MAC strobes.
// Revision : 1.0  initial release
// ============================================================================
module fir_mac_sequencer #(
  parameter int DATA_WIDTH  = 24,
  parameter int FIR_DEPTH   = 16,
  parameter int SAMPLE_LAT  = 2,
  parameter int WEIGHT_LAT  = 1,
  localparam int ADDR_WIDTH = $clog2(FIR_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_din_valid,
  output logic                  o_ready,
  output logic                  o_we_sample,
  output logic                  o_zero_din,
  output logic [ADDR_WIDTH-1:0] o_addr_sample,
  output logic [ADDR_WIDTH-1:0] o_addr_weight,
  output logic                  o_mac_en,
  output logic                  o_mac_first,
  output logic                  o_mac_last,
  output logic                  o_dout_valid
);

  // Weight ROM is faster than the sample RAM; its address is issued later.
  localparam int                  WDLY    = SAMPLE_LAT - WEIGHT_LAT;
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(FIR_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH + 1)'(FIR_DEPTH);

  if (DATA_WIDTH < 1 || FIR_DEPTH < 2 || SAMPLE_LAT < 1 || WEIGHT_LAT > SAMPLE_LAT)
  begin : g_param_check
    $error("fir_mac_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   k_q, k_d;
  logic                    done_q;
  logic [SAMPLE_LAT-1:0]   tv_q, tf_q, tl_q;
  logic [ADDR_WIDTH-1:0]   whold_q;

  logic                    w_go;
  logic                    w_issue;
  logic                    w_last_out;
  logic [ADDR_WIDTH:0]     w_wrap;
  logic [ADDR_WIDTH-1:0]   w_rd_addr;
  logic                    w_wvalid;
  logic [ADDR_WIDTH-1:0]   w_waddr;

  // Strobes are only allowed out when enabled and not in reset.
  assign w_go       = i_en & ~i_rst;
  assign w_issue    = (state_q == S_READ);
  assign w_last_out = tv_q[SAMPLE_LAT-1] & tl_q[SAMPLE_LAT-1];

  // Circular read address: (base - k) mod FIR_DEPTH, valid for any depth.
  assign w_wrap    = DEPTH_X + {1'b0, base_q} - {1'b0, k_q};
  assign w_rd_addr = (base_q >= k_q) ? (base_q - k_q) : w_wrap[ADDR_WIDTH-1:0];

  // State and counters advance only on enabled cycles; reset always wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_CLEAR;
      wr_ptr_q  <= '0;
      clr_cnt_q <= '0;
      base_q    <= '0;
      k_q       <= '0;
      done_q    <= 1'b0;
    end else if (i_en) begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      clr_cnt_q <= clr_cnt_d;
      base_q    <= base_d;
      k_q       <= k_d;
      done_q    <= (state_q == S_DRAIN) & w_last_out;
    end
  end

  // Next-state and memory-side outputs.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    clr_cnt_d     = clr_cnt_q;
    base_d        = base_q;
    k_d           = k_q;
    o_we_sample   = 1'b0;
    o_zero_din    = 1'b0;
    o_addr_sample = wr_ptr_q;
    case (state_q)
      S_CLEAR: begin
        o_we_sample   = w_go;
        o_zero_din    = w_go;
        o_addr_sample = clr_cnt_q;
        if (clr_cnt_q == LAST) begin
          clr_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + ONE;
        end
      end
      S_IDLE: begin
        o_addr_sample = wr_ptr_q;
        if (i_din_valid) begin
          o_we_sample = w_go;
          base_d      = wr_ptr_q;
          wr_ptr_d    = (wr_ptr_q == LAST) ? '0 : (wr_ptr_q + ONE);
          k_d         = '0;
          state_d     = S_READ;
        end
      end
      S_READ: begin
        o_addr_sample = w_rd_addr;
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + ONE;
        end
      end
      S_DRAIN: begin
        o_addr_sample = w_rd_addr;
        if (w_last_out) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Tap-valid/first/last pipe matching the sample RAM read latency.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tv_q <= '0;
      tf_q <= '0;
      tl_q <= '0;
    end else if (i_en) begin
      tv_q[0] <= w_issue;
      tf_q[0] <= w_issue & (k_q == '0);
      tl_q[0] <= w_issue & (k_q == LAST);
      for (int i = 1; i < SAMPLE_LAT; i++) begin
        tv_q[i] <= tv_q[i-1];
        tf_q[i] <= tf_q[i-1];
        tl_q[i] <= tl_q[i-1];
      end
    end
  end

  if (WDLY == 0) begin : g_wdly_none
    assign w_wvalid = w_issue;
    assign w_waddr  = k_q;
  end else begin : g_wdly_pipe
    logic [WDLY-1:0]       wv_q;
    logic [ADDR_WIDTH-1:0] wa_q [WDLY];

    // Delays the weight address so ROM data lands with the sample data.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        wv_q <= '0;
        for (int i = 0; i < WDLY; i++) wa_q[i] <= '0;
      end else if (i_en) begin
        wv_q[0] <= w_issue;
        wa_q[0] <= k_q;
        for (int i = 1; i < WDLY; i++) begin
          wv_q[i] <= wv_q[i-1];
          wa_q[i] <= wa_q[i-1];
        end
      end
    end

    assign w_wvalid = wv_q[WDLY-1];
    assign w_waddr  = wa_q[WDLY-1];
  end

  // Keeps the weight address stable outside valid tap slots.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      whold_q <= '0;
    end else if (i_en && w_wvalid) begin
      whold_q <= w_waddr;
    end
  end

  assign o_addr_weight = w_wvalid ? w_waddr : whold_q;
  assign o_ready       = (state_q == S_IDLE) & ~i_rst;
  assign o_mac_en      = w_go & tv_q[SAMPLE_LAT-1];
  assign o_mac_first   = w_go & tv_q[SAMPLE_LAT-1] & tf_q[SAMPLE_LAT-1];
  assign o_mac_last    = w_go & w_last_out;
  assign o_dout_valid  = w_go & done_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_sequencer
// Purpose  : Scoreboard bench for fir_mac_sequencer. Expected writes, reads,
//            weight addresses, MAC strobes and result pulses are queued at
//            each handshake and compared as the enabled cycles occur.
// Revision : 1.0  initial release
// ============================================================================
module tb_fir_mac_sequencer;
  localparam int N  = 16;
  localparam int SL = 2;
  localparam int WL = 1;
  localparam int AW = $clog2(N);
  localparam int LAT = N + SL + 1;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_en = 1'b1;
  logic          i_din_valid = 1'b0;
  logic          o_ready, o_we_sample, o_zero_din;
  logic [AW-1:0] o_addr_sample, o_addr_weight;
  logic          o_mac_en, o_mac_first, o_mac_last, o_dout_valid;

  fir_mac_sequencer #(
    .DATA_WIDTH(24), .FIR_DEPTH(N), .SAMPLE_LAT(SL), .WEIGHT_LAT(WL)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_din_valid(i_din_valid),
    .o_ready(o_ready), .o_we_sample(o_we_sample), .o_zero_din(o_zero_din),
    .o_addr_sample(o_addr_sample), .o_addr_weight(o_addr_weight),
    .o_mac_en(o_mac_en), .o_mac_first(o_mac_first), .o_mac_last(o_mac_last),
    .o_dout_valid(o_dout_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {int t; int a; int b;} ev_t;
  ev_t q_wr[$], q_rd[$], q_wa[$], q_mac[$], q_dv[$];
  int  hs_cyc[$], hs_addr[$];
  int  checks = 0, errors = 0;
  int  ecyc = 0, cyc = 0, ready_at = 0, wp = 0, dv_count = 0, last_dv_cyc = -1;
  bit  in_rst = 1'b1;

  ev_t       m_e;
  bit        m_rdy, m_hit;
  logic [2:0] m_want;

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge i_clk) begin
    cyc++;
    if (i_rst) begin
      checks++;
      if ({o_we_sample, o_zero_din, o_mac_en, o_mac_first, o_mac_last, o_dout_valid, o_ready} !== 7'b0) begin
        errors++;
        $display("FAIL reset_quiet cyc=%0d got=%b want=0000000", cyc,
                 {o_we_sample, o_zero_din, o_mac_en, o_mac_first, o_mac_last, o_dout_valid, o_ready});
      end
      q_wr.delete(); q_rd.delete(); q_wa.delete(); q_mac.delete(); q_dv.delete();
      in_rst = 1'b1;
    end else begin
      if (in_rst) begin
        for (int k = 0; k < N; k++) begin
          m_e.t = ecyc + k; m_e.a = k; m_e.b = 1; q_wr.push_back(m_e);
        end
        ready_at = ecyc + N;
        wp       = 0;
        in_rst   = 1'b0;
      end
      if (!i_en) begin
        checks++;
        if ({o_we_sample, o_mac_en, o_mac_first, o_mac_last, o_dout_valid} !== 5'b0) begin
          errors++;
          $display("FAIL en_low_quiet cyc=%0d got=%b want=00000", cyc,
                   {o_we_sample, o_mac_en, o_mac_first, o_mac_last, o_dout_valid});
        end
      end else begin
        m_rdy = (ecyc >= ready_at);
        checks++;
        if (o_ready !== m_rdy) begin
          errors++;
          $display("FAIL ready cyc=%0d got=%b want=%b", cyc, o_ready, m_rdy);
        end
        if (i_din_valid && m_rdy) begin
          m_e.t = ecyc; m_e.a = wp; m_e.b = 0; q_wr.push_back(m_e);
          for (int k = 0; k < N; k++) begin
            m_e.t = ecyc + 1 + k;             m_e.a = (wp - k + N) % N; m_e.b = 0; q_rd.push_back(m_e);
            m_e.t = ecyc + 1 + (SL - WL) + k; m_e.a = k;                m_e.b = 0; q_wa.push_back(m_e);
            m_e.t = ecyc + 1 + SL + k;        m_e.a = (k == 0);         m_e.b = (k == N - 1); q_mac.push_back(m_e);
          end
          m_e.t = ecyc + LAT; m_e.a = 0; m_e.b = 0; q_dv.push_back(m_e);
          hs_cyc.push_back(cyc);
          hs_addr.push_back(wp);
          wp       = (wp + 1) % N;
          ready_at = ecyc + LAT;
        end
        // sample RAM writes
        m_hit = (q_wr.size() > 0) && (q_wr[0].t == ecyc);
        if (m_hit) m_e = q_wr.pop_front();
        checks++;
        if (o_we_sample !== m_hit || o_zero_din !== (m_hit && m_e.b == 1)) begin
          errors++;
          $display("FAIL write_en cyc=%0d got we=%b zero=%b want we=%b zero=%b", cyc,
                   o_we_sample, o_zero_din, m_hit, (m_hit && m_e.b == 1));
        end
        if (m_hit) begin
          checks++;
          if (o_addr_sample !== AW'(m_e.a)) begin
            errors++;
            $display("FAIL write_addr cyc=%0d got=%0d want=%0d", cyc, o_addr_sample, m_e.a);
          end
        end
        // sample RAM read addresses
        if (q_rd.size() > 0 && q_rd[0].t == ecyc) begin
          m_e = q_rd.pop_front();
          checks++;
          if (o_addr_sample !== AW'(m_e.a)) begin
            errors++;
            $display("FAIL read_addr cyc=%0d got=%0d want=%0d", cyc, o_addr_sample, m_e.a);
          end
        end
        // weight ROM addresses
        if (q_wa.size() > 0 && q_wa[0].t == ecyc) begin
          m_e = q_wa.pop_front();
          checks++;
          if (o_addr_weight !== AW'(m_e.a)) begin
            errors++;
            $display("FAIL weight_addr cyc=%0d got=%0d want=%0d", cyc, o_addr_weight, m_e.a);
          end
        end
        // MAC strobes
        m_want = 3'b000;
        if (q_mac.size() > 0 && q_mac[0].t == ecyc) begin
          m_e    = q_mac.pop_front();
          m_want = {1'b1, m_e.a[0], m_e.b[0]};
        end
        checks++;
        if ({o_mac_en, o_mac_first, o_mac_last} !== m_want) begin
          errors++;
          $display("FAIL mac_strobes cyc=%0d got=%b want=%b", cyc,
                   {o_mac_en, o_mac_first, o_mac_last}, m_want);
        end
        // result pulse
        m_hit = (q_dv.size() > 0) && (q_dv[0].t == ecyc);
        if (m_hit) m_e = q_dv.pop_front();
        checks++;
        if (o_dout_valid !== m_hit) begin
          errors++;
          $display("FAIL dout_valid cyc=%0d got=%b want=%b", cyc, o_dout_valid, m_hit);
        end
        if (o_dout_valid === 1'b1) begin
          dv_count++;
          last_dv_cyc = cyc;
        end
        ecyc++;
      end
    end
  end

  task automatic do_reset(input int n);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    repeat (n) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic send_one(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge i_clk); #1;
      if (o_ready === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout got ready=%b want ready=1 within 200 cycles", o_ready);
    end else begin
      i_din_valid = 1'b1;
      @(posedge i_clk); #1;
      i_din_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    i_en = 1'b1;
    do_reset(3);
    repeat (N - 1) @(posedge i_clk);
    #1;
    checks++;
    if (o_ready !== 1'b0 || o_we_sample !== 1'b1 || o_zero_din !== 1'b1 || o_addr_sample !== AW'(N - 1)) begin
      errors++;
      $display("FAIL clear_last got rdy=%b we=%b zero=%b addr=%0d want rdy=0 we=1 zero=1 addr=%0d",
               o_ready, o_we_sample, o_zero_din, o_addr_sample, N - 1);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_ready !== 1'b1 || o_we_sample !== 1'b0) begin
      errors++;
      $display("FAIL clear_done got rdy=%b we=%b want rdy=1 we=0", o_ready, o_we_sample);
    end
  endtask

  task automatic test_single();
    bit ok;
    int n0;
    do_reset(2);
    hs_cyc.delete(); hs_addr.delete();
    n0 = dv_count;
    send_one(ok);
    repeat (LAT + 4) @(posedge i_clk);
    #1;
    checks++;
    if (dv_count !== n0 + 1 || hs_addr.size() != 1 || hs_addr[0] != 0) begin
      errors++;
      $display("FAIL single got results=%0d hs=%0d want results=%0d hs=1 addr0", dv_count - n0, hs_addr.size(), 1);
    end else begin
      checks++;
      if (last_dv_cyc - hs_cyc[0] != LAT) begin
        errors++;
        $display("FAIL single_latency got=%0d want=%0d", last_dv_cyc - hs_cyc[0], LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    hs_cyc.delete(); hs_addr.delete();
    i_din_valid = 1'b1;
    for (int i = 0; i < 200 && hs_cyc.size() < 3; i++) begin
      @(posedge i_clk); #1;
    end
    i_din_valid = 1'b0;
    checks++;
    if (hs_cyc.size() != 3) begin
      errors++;
      $display("FAIL b2b_count got=%0d want=3", hs_cyc.size());
    end else begin
      checks++;
      if (hs_cyc[1] - hs_cyc[0] != LAT || hs_cyc[2] - hs_cyc[1] != LAT) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d,%0d want=%0d", hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1], LAT);
      end
      checks++;
      if (hs_addr[0] != 0 || hs_addr[1] != 1 || hs_addr[2] != 2) begin
        errors++;
        $display("FAIL b2b_waddr got=%0d,%0d,%0d want=0,1,2", hs_addr[0], hs_addr[1], hs_addr[2]);
      end
    end
    repeat (LAT + 4) @(posedge i_clk);
  endtask

  task automatic test_wrap();
    do_reset(2);
    hs_cyc.delete(); hs_addr.delete();
    i_din_valid = 1'b1;
    for (int i = 0; i < 17 * LAT + 60 && hs_cyc.size() < 17; i++) begin
      @(posedge i_clk); #1;
    end
    i_din_valid = 1'b0;
    checks++;
    if (hs_cyc.size() != 17 || hs_addr[16] != 0) begin
      errors++;
      $display("FAIL wrap got count=%0d last_addr=%0d want count=17 last_addr=0",
               hs_cyc.size(), (hs_addr.size() > 0) ? hs_addr[hs_addr.size() - 1] : -1);
    end
    repeat (LAT + 4) @(posedge i_clk);
  endtask

  task automatic test_enable_gap();
    bit ok;
    int n0;
    do_reset(2);
    hs_cyc.delete(); hs_addr.delete();
    n0 = dv_count;
    send_one(ok);
    repeat (4) @(posedge i_clk);
    #1 i_en = 1'b0;
    repeat (5) @(posedge i_clk);
    #1 i_en = 1'b1;
    repeat (LAT + 4) @(posedge i_clk);
    #1;
    checks++;
    if (dv_count !== n0 + 1 || hs_cyc.size() != 1) begin
      errors++;
      $display("FAIL en_gap_result got results=%0d want=1", dv_count - n0);
    end else begin
      checks++;
      if (last_dv_cyc - hs_cyc[0] != LAT + 5) begin
        errors++;
        $display("FAIL en_gap_latency got=%0d want=%0d", last_dv_cyc - hs_cyc[0], LAT + 5);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n0;
    do_reset(2);
    hs_cyc.delete(); hs_addr.delete();
    n0 = dv_count;
    send_one(ok);
    repeat (9) @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    repeat (LAT + 4) @(posedge i_clk);
    #1;
    checks++;
    if (dv_count !== n0) begin
      errors++;
      $display("FAIL reset_mid_no_result got=%0d want=0", dv_count - n0);
    end
    send_one(ok);
    repeat (LAT + 4) @(posedge i_clk);
    #1;
    checks++;
    if (hs_addr.size() != 2 || hs_addr[1] != 0 || dv_count !== n0 + 1) begin
      errors++;
      $display("FAIL reset_mid_restart got hs=%0d results=%0d want hs=2 addr=0 results=1",
               hs_addr.size(), dv_count - n0);
    end
  endtask

  task automatic test_leftover();
    checks++;
    if (q_wr.size() + q_rd.size() + q_wa.size() + q_mac.size() + q_dv.size() != 0) begin
      errors++;
      $display("FAIL leftover got=%0d pending events want=0",
               q_wr.size() + q_rd.size() + q_wa.size() + q_mac.size() + q_dv.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_enable_gap();
    test_reset_mid();
    test_leftover();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
